// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline hazard controller bundle: pipeline-side hazard information,
// the data-memory handshake, and the stall/flush/forward controls that the
// controller returns. The controller attaches to the slave modport; the
// pipeline (or a testbench) drives through the master modport.
interface pipe_hazard_ctrl_if;
  // Operand sources of the instructions in EX and ID
  logic [4:0]  ex_rs;
  logic [4:0]  ex_rt;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_uses_rt;
  // Writer information for EX, EX/MEM and MEM/WB
  logic        ex_mem_read;
  logic [4:0]  ex_write_reg;
  logic        mem_reg_write;
  logic [4:0]  mem_write_reg;
  logic        wb_reg_write;
  logic [4:0]  wb_write_reg;
  // Branch resolution and data-memory handshake
  logic        br_taken;
  logic        dmem_req;
  logic        dmem_ack;
  // Pipeline register controls
  logic        pc_stall;
  logic        ifid_stall;
  logic        idex_stall;
  logic        exmem_stall;
  logic        idex_bubble;
  logic        ifid_flush;
  logic        idex_flush;
  logic        exmem_flush;
  logic        memwb_bubble;
  // Forwarding selects, status and performance counters
  logic [1:0]  fwd_a;
  logic [1:0]  fwd_b;
  logic        mem_err;
  logic [1:0]  state;
  logic [15:0] stall_cycles;
  logic [15:0] flush_count;

  modport master (
    output ex_rs, ex_rt, id_rs, id_rt, id_uses_rt,
    output ex_mem_read, ex_write_reg, mem_reg_write, mem_write_reg,
    output wb_reg_write, wb_write_reg, br_taken, dmem_req, dmem_ack,
    input  pc_stall, ifid_stall, idex_stall, exmem_stall, idex_bubble,
    input  ifid_flush, idex_flush, exmem_flush, memwb_bubble,
    input  fwd_a, fwd_b, mem_err, state, stall_cycles, flush_count
  );

  modport slave (
    input  ex_rs, ex_rt, id_rs, id_rt, id_uses_rt,
    input  ex_mem_read, ex_write_reg, mem_reg_write, mem_write_reg,
    input  wb_reg_write, wb_write_reg, br_taken, dmem_req, dmem_ack,
    output pc_stall, ifid_stall, idex_stall, exmem_stall, idex_bubble,
    output ifid_flush, idex_flush, exmem_flush, memwb_bubble,
    output fwd_a, fwd_b, mem_err, state, stall_cycles, flush_count
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Five-stage pipeline hazard controller: load-use stall, branch flush,
// EX operand forwarding, and a data-memory wait FSM that freezes the whole
// pipeline while an access is outstanding and latches a sticky error on
// timeout. Synchronous active-high reset.
// Optional build macro HAZARD_PERF_CNT_EN adds saturating stall/flush
// performance counters; without it both counter outputs read zero.
module pipe_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 8   // 1..255 wait cycles before ERR
) (
  input  logic               clk,
  input  logic               rst,
  pipe_hazard_ctrl_if.slave  hz
);

  localparam logic [1:0] RUN  = 2'b00;
  localparam logic [1:0] WAIT = 2'b01;
  localparam logic [1:0] ERR  = 2'b10;

  localparam logic [7:0] TIMEOUT_CNT = MEM_TIMEOUT[7:0];

  logic [1:0] stateQ;
  logic [7:0] waitCnt;
  logic       memErr;
  logic       freeze;
  logic       loadUse;

  // Forward from the youngest matching writer; register 0 never forwards.
  function automatic logic [1:0] fwdSel(
    input logic [4:0] src,
    input logic       memWr,
    input logic [4:0] memReg,
    input logic       wbWr,
    input logic [4:0] wbReg
  );
    if (memWr && memReg != 5'd0 && memReg == src)
      return 2'b10;
    else if (wbWr && wbReg != 5'd0 && wbReg == src)
      return 2'b01;
    else
      return 2'b00;
  endfunction

  // Freeze whenever the memory stage cannot complete this cycle; ERR and the
  // unused encoding freeze forever.
  always_comb begin
    // NOTE: every combinational output is given a default first so that no
    // path through the block leaves it unassigned and infers a latch.
    freeze = 1'b0;
    case (stateQ)
      RUN:     freeze = hz.dmem_req && !hz.dmem_ack;
      WAIT:    freeze = !hz.dmem_ack;
      default: freeze = 1'b1;
    endcase
  end

  assign loadUse = hz.ex_mem_read && (hz.ex_write_reg != 5'd0) &&
                   ((hz.ex_write_reg == hz.id_rs) ||
                    (hz.id_uses_rt && hz.ex_write_reg == hz.id_rt));

  // Pipeline register controls, by priority: reset, freeze, branch, load-use.
  always_comb begin
    hz.pc_stall     = 1'b0;
    hz.ifid_stall   = 1'b0;
    hz.idex_stall   = 1'b0;
    hz.exmem_stall  = 1'b0;
    hz.idex_bubble  = 1'b0;
    hz.ifid_flush   = 1'b0;
    hz.idex_flush   = 1'b0;
    hz.exmem_flush  = 1'b0;
    hz.memwb_bubble = 1'b0;
    if (rst) begin
      hz.ifid_flush   = 1'b1;
      hz.idex_flush   = 1'b1;
      hz.exmem_flush  = 1'b1;
      hz.memwb_bubble = 1'b1;
    end else if (freeze) begin
      // A taken branch is simply held in EX/MEM and flushes once unfrozen.
      hz.pc_stall     = 1'b1;
      hz.ifid_stall   = 1'b1;
      hz.idex_stall   = 1'b1;
      hz.exmem_stall  = 1'b1;
      hz.memwb_bubble = 1'b1;
    end else if (hz.br_taken) begin
      // The branch discards the dependent instruction, so no stall is needed.
      hz.ifid_flush   = 1'b1;
      hz.idex_flush   = 1'b1;
      hz.exmem_flush  = 1'b1;
    end else if (loadUse) begin
      hz.pc_stall     = 1'b1;
      hz.ifid_stall   = 1'b1;
      hz.idex_bubble  = 1'b1;
    end
  end

  // Operand forwarding is independent of freeze and FSM state.
  always_comb begin
    hz.fwd_a = fwdSel(hz.ex_rs, hz.mem_reg_write, hz.mem_write_reg,
                      hz.wb_reg_write, hz.wb_write_reg);
    hz.fwd_b = fwdSel(hz.ex_rt, hz.mem_reg_write, hz.mem_write_reg,
                      hz.wb_reg_write, hz.wb_write_reg);
  end

  // Data-memory wait FSM with timeout counter and sticky error flag.
  always_ff @(posedge clk) begin
    // NOTE: registered state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      stateQ  <= RUN;
      waitCnt <= '0;
      memErr  <= 1'b0;
    end else begin
      case (stateQ)
        RUN: begin
          if (hz.dmem_req && !hz.dmem_ack) begin
            stateQ  <= WAIT;
            waitCnt <= 8'd1;
          end
        end
        WAIT: begin
          if (hz.dmem_ack) begin
            stateQ  <= RUN;
            waitCnt <= '0;
          end else if (waitCnt == TIMEOUT_CNT) begin
            stateQ  <= ERR;
            memErr  <= 1'b1;
          end else begin
            waitCnt <= waitCnt + 8'd1;
          end
        end
        default: ;  // ERR holds until reset; acknowledges are ignored
      endcase
    end
  end

  assign hz.state   = stateQ;
  assign hz.mem_err = memErr;

`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] stallCnt;
  logic [15:0] flushCnt;
  logic        stallEvent;
  logic        flushEvent;

  // A stall cycle is a frozen cycle or a load-use stall the branch did not override.
  assign stallEvent = freeze || (!hz.br_taken && loadUse);
  assign flushEvent = !freeze && hz.br_taken;

  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      stallCnt <= '0;
      flushCnt <= '0;
    end else begin
      if (stallEvent && stallCnt != 16'hFFFF)
        stallCnt <= stallCnt + 16'd1;
      if (flushEvent && flushCnt != 16'hFFFF)
        flushCnt <= flushCnt + 16'd1;
    end
  end

  assign hz.stall_cycles = stallCnt;
  assign hz.flush_count  = flushCnt;
`else
  assign hz.stall_cycles = '0;
  assign hz.flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed testbench for pipe_hazard_ctrl (MEM_TIMEOUT=4). Inputs change on
// the falling edge and outputs are sampled 1 ns later, so every window
// contains exactly one rising edge after its checks. Counter expectations
// collapse to zero when HAZARD_PERF_CNT_EN is not defined.
module tb_pipe_hazard_ctrl;

`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF_EN = 1'b1;
`else
  localparam bit PERF_EN = 1'b0;
`endif

  // Control vector bit order:
  // {pc_stall, ifid_stall, idex_stall, exmem_stall, idex_bubble,
  //  ifid_flush, idex_flush, exmem_flush, memwb_bubble}
  localparam logic [8:0] CTL_NONE   = 9'b000000000;
  localparam logic [8:0] CTL_STALL  = 9'b110010000;
  localparam logic [8:0] CTL_FLUSH  = 9'b000001110;
  localparam logic [8:0] CTL_FREEZE = 9'b111100001;
  localparam logic [8:0] CTL_RST    = 9'b000001111;

  logic clk = 1'b0;
  logic rst;
  int   nChecks = 0;
  int   nErrors = 0;
  logic [8:0] ctl;

  pipe_hazard_ctrl_if hz ();

  pipe_hazard_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  always #5 clk = ~clk;

  assign ctl = {hz.pc_stall, hz.ifid_stall, hz.idex_stall, hz.exmem_stall,
                hz.idex_bubble, hz.ifid_flush, hz.idex_flush, hz.exmem_flush,
                hz.memwb_bubble};

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic checkCnt(input int stallExp, input int flushExp);
    check("stall_cycles", 32'(hz.stall_cycles), PERF_EN ? stallExp : 0);
    check("flush_count",  32'(hz.flush_count),  PERF_EN ? flushExp : 0);
  endtask

  task automatic setIdle();
    hz.ex_rs = 5'd0;  hz.ex_rt = 5'd0;  hz.id_rs = 5'd0;  hz.id_rt = 5'd0;
    hz.id_uses_rt = 1'b0;  hz.ex_mem_read = 1'b0;  hz.ex_write_reg = 5'd0;
    hz.mem_reg_write = 1'b0;  hz.mem_write_reg = 5'd0;
    hz.wb_reg_write = 1'b0;   hz.wb_write_reg = 5'd0;
    hz.br_taken = 1'b0;  hz.dmem_req = 1'b0;  hz.dmem_ack = 1'b0;
  endtask

  // Advance to the next falling edge (one rising edge has passed).
  task automatic nextWin();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    setIdle();

    // Reset: flushes and MEM/WB bubble asserted, no stalls
    nextWin(); #1;
    check("rst_ctl", 32'(ctl), 32'(CTL_RST));

    nextWin();
    check("rst_state", 32'(hz.state), 32'd0);
    check("rst_mem_err", 32'(hz.mem_err), 32'd0);
    checkCnt(0, 0);
    rst = 1'b0; #1;
    check("idle_ctl", 32'(ctl), 32'(CTL_NONE));

    // Load-use via rs
    nextWin();
    hz.ex_mem_read = 1'b1; hz.ex_write_reg = 5'd5; hz.id_rs = 5'd5; #1;
    check("lu_rs", 32'(ctl), 32'(CTL_STALL));                     // stall 1

    nextWin();
    hz.ex_write_reg = 5'd0; hz.id_rs = 5'd0; #1;
    check("lu_r0", 32'(ctl), 32'(CTL_NONE));

    // Load-use via rt, then rt not read
    nextWin();
    hz.ex_write_reg = 5'd9; hz.id_rt = 5'd9; hz.id_uses_rt = 1'b1; hz.id_rs = 5'd3; #1;
    check("lu_rt", 32'(ctl), 32'(CTL_STALL));                     // stall 2

    nextWin();
    hz.id_uses_rt = 1'b0; #1;
    check("lu_rt_unused", 32'(ctl), 32'(CTL_NONE));

    // Branch with simultaneous load-use: branch wins
    nextWin();
    hz.id_rs = 5'd9; hz.br_taken = 1'b1; #1;
    check("br_lu", 32'(ctl), 32'(CTL_FLUSH));                     // flush 1
    checkCnt(2, 0);

    nextWin();
    hz.br_taken = 1'b0; hz.ex_mem_read = 1'b0; #1;
    check("after_br", 32'(ctl), 32'(CTL_NONE));
    checkCnt(2, 1);

    // Forwarding
    nextWin();
    hz.mem_reg_write = 1'b1; hz.mem_write_reg = 5'd7;
    hz.wb_reg_write  = 1'b1; hz.wb_write_reg  = 5'd7;
    hz.ex_rs = 5'd7; hz.ex_rt = 5'd7; #1;
    check("fwd_a_mem", 32'(hz.fwd_a), 32'd2);
    check("fwd_b_mem", 32'(hz.fwd_b), 32'd2);

    hz.mem_reg_write = 1'b0; #1;
    check("fwd_a_wb", 32'(hz.fwd_a), 32'd1);
    check("fwd_b_wb", 32'(hz.fwd_b), 32'd1);

    hz.mem_reg_write = 1'b1; hz.mem_write_reg = 5'd0; hz.wb_write_reg = 5'd0;
    hz.ex_rs = 5'd0; hz.ex_rt = 5'd0; #1;
    check("fwd_a_r0", 32'(hz.fwd_a), 32'd0);
    check("fwd_b_r0", 32'(hz.fwd_b), 32'd0);

    hz.mem_write_reg = 5'd4; hz.wb_write_reg = 5'd3;
    hz.ex_rs = 5'd3; hz.ex_rt = 5'd4; #1;
    check("fwd_a_split", 32'(hz.fwd_a), 32'd1);
    check("fwd_b_split", 32'(hz.fwd_b), 32'd2);

    // Memory wait: 3 frozen cycles then acknowledge
    nextWin();
    hz.dmem_req = 1'b1; #1;
    check("mw0_state", 32'(hz.state), 32'd0);
    check("mw0_ctl", 32'(ctl), 32'(CTL_FREEZE));                  // stall 3
    nextWin(); #1;
    check("mw1_state", 32'(hz.state), 32'd1);
    check("mw1_ctl", 32'(ctl), 32'(CTL_FREEZE));                  // stall 4
    check("mw1_fwd_a", 32'(hz.fwd_a), 32'd1);
    nextWin(); #1;
    check("mw2_state", 32'(hz.state), 32'd1);
    check("mw2_ctl", 32'(ctl), 32'(CTL_FREEZE));                  // stall 5
    nextWin();
    hz.dmem_ack = 1'b1; #1;
    check("mw_ack_state", 32'(hz.state), 32'd1);
    check("mw_ack_ctl", 32'(ctl), 32'(CTL_NONE));
    nextWin();
    setIdle(); #1;
    check("mw_done_state", 32'(hz.state), 32'd0);
    check("mw_done_ctl", 32'(ctl), 32'(CTL_NONE));
    checkCnt(5, 1);

    // Branch during wait: deferred to the acknowledge cycle
    nextWin();
    hz.dmem_req = 1'b1; hz.br_taken = 1'b1; #1;
    check("bw0_ctl", 32'(ctl), 32'(CTL_FREEZE));                  // stall 6
    nextWin(); #1;
    check("bw1_ctl", 32'(ctl), 32'(CTL_FREEZE));                  // stall 7
    nextWin();
    hz.dmem_ack = 1'b1; #1;
    check("bw_ack_ctl", 32'(ctl), 32'(CTL_FLUSH));                // flush 2
    nextWin();
    setIdle(); #1;
    check("bw_done_state", 32'(hz.state), 32'd0);
    checkCnt(7, 2);

    // Timeout: 1 RUN + 4 WAIT cycles without acknowledge reach ERR
    nextWin();
    hz.dmem_req = 1'b1; #1;
    check("to_run_ctl", 32'(ctl), 32'(CTL_FREEZE));               // stall 8
    for (int i = 0; i < 4; i++) begin
      nextWin(); #1;                                              // stall 9..12
      check("to_wait_state", 32'(hz.state), 32'd1);
      check("to_wait_err", 32'(hz.mem_err), 32'd0);
    end
    nextWin();
    hz.dmem_req = 1'b0; hz.dmem_ack = 1'b1; #1;
    check("to_err_state", 32'(hz.state), 32'd2);
    check("to_err_flag", 32'(hz.mem_err), 32'd1);
    check("to_err_ctl", 32'(ctl), 32'(CTL_FREEZE));               // stall 13
    nextWin(); #1;
    check("err_sticky_state", 32'(hz.state), 32'd2);
    check("err_sticky_ctl", 32'(ctl), 32'(CTL_FREEZE));
    checkCnt(13, 2);
    rst = 1'b1; #1;
    check("err_rst_ctl", 32'(ctl), 32'(CTL_RST));
    nextWin();
    rst = 1'b0; setIdle(); #1;
    check("post_rst_state", 32'(hz.state), 32'd0);
    check("post_rst_err", 32'(hz.mem_err), 32'd0);
    check("post_rst_ctl", 32'(ctl), 32'(CTL_NONE));
    checkCnt(0, 0);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 8, max consecutive data-memory wait cycles before error (range 1..255).
REQ-002 SHALL have ports clk in 1 clock; rst in 1 reset; ex_rs, ex_rt in 5 EX-stage sources; id_rs, id_rt in 5 ID-stage sources; id_uses_rt in 1 ID reads rt.
REQ-003 SHALL have ports ex_mem_read in 1 EX is load; ex_write_reg in 5 EX destination; mem_reg_write in 1, mem_write_reg in 5 EX/MEM writer; wb_reg_write in 1, wb_write_reg in 5 MEM/WB writer.
REQ-004 SHALL have ports br_taken in 1 branch resolved taken (EX/MEM zero AND branch); dmem_req in 1 MEM stage accesses data memory; dmem_ack in 1 data memory done.
REQ-005 SHALL have outputs pc_stall, ifid_stall, idex_stall, exmem_stall 1 each hold register; idex_bubble 1 load zero controls into ID/EX; ifid_flush, idex_flush, exmem_flush 1 each clear register; memwb_bubble 1 clear MEM/WB controls.
REQ-006 SHALL have outputs fwd_a, fwd_b 2 ALU operand select; mem_err 1 sticky timeout; state 2 FSM state; stall_cycles 16, flush_count 16 performance counters.
REQ-007 SHALL use one clock clk; reset rst is synchronous, active-high.

Function
REQ-008 SHALL implement FSM states RUN=00, WAIT=01, ERR=10; 11 unreachable, decoded as ERR.
REQ-009 freeze SHALL be 1 when (RUN and dmem_req and !dmem_ack), or WAIT and !dmem_ack, or ERR; else 0.
REQ-010 freeze=1 SHALL assert pc_stall, ifid_stall, idex_stall, exmem_stall, memwb_bubble, and SHALL deassert all flush and idex_bubble outputs.
REQ-011 RUN->WAIT when dmem_req and !dmem_ack; wait_cnt loads 1.
REQ-012 WAIT: dmem_ack=1 -> RUN, no freeze that cycle; else wait_cnt increments; wait_cnt==MEM_TIMEOUT with !dmem_ack -> ERR, mem_err=1 next edge.
REQ-013 ERR SHALL persist until rst; dmem_ack ignored.
REQ-014 Load-use hazard = ex_mem_read and ex_write_reg!=0 and (ex_write_reg==id_rs or (id_uses_rt and ex_write_reg==id_rt)).
REQ-015 With freeze=0, br_taken=0, hazard=1: pc_stall=ifid_stall=idex_bubble=1 for exactly that cycle (combinational, 1-cycle stall).
REQ-016 With freeze=0, br_taken=1: ifid_flush=idex_flush=exmem_flush=1 same cycle; load-use stall suppressed (branch wins).
REQ-017 br_taken during freeze SHALL be deferred: flush asserted in the first non-frozen cycle in which br_taken is still 1 (EX/MEM held, so it is).
REQ-018 fwd_a SHALL be 10 if mem_reg_write and mem_write_reg!=0 and mem_write_reg==ex_rs; else 01 if wb_reg_write and wb_write_reg!=0 and wb_write_reg==ex_rs; else 00. fwd_b identical using ex_rt.
REQ-019 fwd_a/fwd_b SHALL be combinational, independent of freeze and state.
REQ-020 All stall/flush/bubble outputs SHALL be combinational from current state and inputs; zero latency.
REQ-021 state output SHALL equal registered FSM state.

Reset
REQ-022 rst=1 at edge: state=RUN, wait_cnt=0, mem_err=0, stall_cycles=0, flush_count=0.
REQ-023 While rst=1: ifid_flush=idex_flush=exmem_flush=memwb_bubble=1, all stalls=0, idex_bubble=0.
REQ-024 rst mid-WAIT or in ERR SHALL return to RUN next edge, abandoning the pending access.

Configuration
REQ-025 Macro HAZARD_PERF_CNT_EN defined: stall_cycles +1 each cycle with freeze=1 or load-use stall; flush_count +1 each non-frozen cycle with br_taken=1; both saturate at 16'hFFFF.
REQ-026 HAZARD_PERF_CNT_EN undefined: counters not built; stall_cycles and flush_count tied to 0; all other behaviour identical.

Verification
REQ-027 ex_mem_read=1, ex_write_reg=5, id_rs=5 -> pc_stall=ifid_stall=idex_bubble=1 one cycle; id_rs=0, ex_write_reg=0 -> no stall.
REQ-028 br_taken=1 with simultaneous load-use hazard -> three flushes=1, pc_stall=0; flush_count 0->1 (PERF_EN).
REQ-029 dmem_req=1, dmem_ack=0 for 3 cycles then ack -> freeze 3 cycles, state 00->01->01->00, release on ack cycle; stall_cycles=3.
REQ-030 MEM_TIMEOUT=4, dmem_ack held 0 -> ERR after 5th cycle (1 RUN + 4 WAIT), mem_err=1, freeze persists; rst=1 -> state=00, mem_err=0.
REQ-031 mem_write_reg=wb_write_reg=7, both writers, ex_rs=7 -> fwd_a=10; mem_reg_write=0 -> 01; write_reg=0 -> 00.
REQ-032 br_taken=1 during WAIT -> no flush while frozen; flushes asserted on ack cycle.
